mps_op_cmd_arbiter: RTL and testbench
=====================================

Name: mps_op_cmd_arbiter

Overview:
Arbitrates operation ON/OFF commands from several requesters (remote/EPICS, local HMI, external DI) into single-cycle i_op_on_flag / i_op_off_flag pulses for MPS_Operation_FSM. Tracks FSM progress through its on_state/off_state codes and reports per-command completion, failure or rejection back to the owning requester. Enforces one command in flight, OFF-over-ON priority, interlock lockout and a wait timeout.

Parameters:
N_REQ, 3, number of requesters (1..8); index 0 has highest fixed priority.
TO_CYCLES, 32'd2000000000, max cycles in a WAIT state before timeout fail (20 s at 100 MHz).
OWN_W, 3, width of the owner index (>= clog2(N_REQ)).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  synchronous, active-high reset.
i_on_req  in  N_REQ  level ON requests; rising edge = command.
i_off_req  in  N_REQ  level OFF requests; rising edge = command.
i_req_en  in  N_REQ  requester enable mask (local/remote mode); a disabled requester's edges are ignored silently.
i_intl  in  1  combined interlock, level.
i_on_state  in  4  on_state from the operation FSM.
i_off_state  in  4  off_state from the operation FSM.
o_op_on_flag  out  1  one-cycle ON command pulse to the FSM.
o_op_off_flag  out  1  one-cycle OFF command pulse to the FSM.
o_owner  out  OWN_W  index of the requester owning the current/last command.
o_busy  out  1  command in flight.
o_sys_on  out  1  system believed ON.
o_done  out  N_REQ  one-cycle pulse to the owner on success.
o_fail  out  N_REQ  one-cycle pulse to the owner on FSM fail or timeout.
o_reject  out  N_REQ  one-cycle pulse per rejected request.
o_arb_state  out  3  current arbiter state, for status registers.

Behaviour:
- Reset: state A_IDLE; all outputs 0; edge-detect registers loaded with 0; wait counter 0.
- Edge detect: req_edge = i_x_req & ~prev & i_req_en, registered inputs; decision the cycle after the edge. Edges that are not granted in that cycle are dropped (no queueing).
- FSM codes: A_IDLE=0, A_ON_ISSUE=1, A_ON_WAIT=2, A_OFF_ISSUE=3, A_OFF_WAIT=4.
- A_IDLE: any OFF edge wins over any ON edge. Among same type, the lowest index wins. Losers in the same cycle get o_reject.
  - OFF accepted when o_sys_on=1 -> A_OFF_ISSUE; otherwise the OFF is rejected.
  - ON accepted when o_sys_on=0 and i_intl=0 and i_on_state==0 -> A_ON_ISSUE; otherwise the ON is rejected.
- A_ON_ISSUE: o_op_on_flag=1 for exactly this cycle; clear the seen_active bit; go to A_ON_WAIT.
- A_ON_WAIT: seen_active is set when i_on_state!=0.
  - i_on_state==14 -> o_done[owner], o_sys_on=1, go to A_IDLE.
  - i_on_state==15, or (seen_active and i_on_state==0), or counter==TO_CYCLES-1 -> o_fail[owner], go to A_IDLE.
  - An OFF edge here (any enabled requester) aborts: owner becomes the OFF winner, the ON owner gets o_fail, go to A_OFF_ISSUE.
- A_OFF_ISSUE: o_op_off_flag=1 for exactly this cycle; go to A_OFF_WAIT.
- A_OFF_WAIT:
  - i_off_state==3 -> o_done[owner], o_sys_on=0, go to A_IDLE.
  - i_off_state==15 or timeout -> o_fail[owner], o_sys_on=0, go to A_IDLE.
- In any non-IDLE state, all new ON edges and all OFF edges except the A_ON_WAIT abort are rejected.
- Interlock: i_intl=1 in A_ON_ISSUE or A_ON_WAIT -> o_fail[owner], o_sys_on=0, go to A_IDLE the next cycle (the FSM handles its own FAIL). i_intl does not affect OFF states.
- Wait counter: 32-bit; cleared on entry to either WAIT state; saturates; compared against TO_CYCLES-1.
- o_busy = (state != A_IDLE); o_owner holds its value until the next grant.
- Simultaneous FSM success and timeout in the same cycle: success wins.

Optional Feature:
MPS_ARB_ROUND_ROBIN_EN: when defined, same-type requests are granted round-robin, starting from the index after the last granted owner. OFF still beats ON. When undefined, fixed priority with the lowest index winning.

Decomposition:
- Package mps_op_pkg holds the arbiter state localparams and the FSM code constants: ON_IDLE=0, SYSTEM_ON=14, FAIL=15, OFF_SYSTEM_OFF=3.
- One sub-module: mps_req_pick, a parameterised priority/round-robin picker (edges in, one-hot grant + index out). It is instantiated twice, once for ON and once for OFF.

Test Plan:
- Req0 ON edge, FSM model reaches on_state 14 after 50 cycles -> single o_op_on_flag pulse 2 cycles after the edge; o_done[0]; o_sys_on=1.
- Same cycle: req1 ON and req2 ON edges -> req1 granted, o_reject[2] pulse; o_owner=1.
- While in A_ON_WAIT, req2 OFF edge -> o_fail[0], then o_op_off_flag; off_state 3 -> o_done[2], o_sys_on=0.
- ON edge with FSM stuck at on_state 4, TO_CYCLES=1000 -> o_fail after exactly 1000 wait cycles; then A_IDLE.
- i_intl=1 during A_ON_WAIT -> o_fail[owner] the next cycle; a new ON edge while i_intl=1 -> o_reject.
- OFF edge with o_sys_on=0 -> o_reject. Disabled requester (i_req_en=0) edge -> no pulse at all.

Source files
------------

// File: rtl/mps_op_pkg.sv
// Shared arbiter state encoding and MPS_Operation_FSM status codes.
// Used by the command arbiter and its request picker.
package mps_op_pkg;

    typedef enum logic [2:0] {
        A_IDLE      = 3'd0,
        A_ON_ISSUE  = 3'd1,
        A_ON_WAIT   = 3'd2,
        A_OFF_ISSUE = 3'd3,
        A_OFF_WAIT  = 3'd4
    } arb_state_e;

    localparam logic [3:0] ON_IDLE        = 4'd0;
    localparam logic [3:0] SYSTEM_ON      = 4'd14;
    localparam logic [3:0] FAIL           = 4'd15;
    localparam logic [3:0] OFF_SYSTEM_OFF = 4'd3;

endpackage

// File: rtl/mps_req_pick.sv
// One-of-N request picker: fixed lowest-index priority by default,
// round-robin after `last` when MPS_ARB_ROUND_ROBIN_EN is defined.
module mps_req_pick
    import mps_op_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int start;

`ifdef MPS_ARB_ROUND_ROBIN_EN
    assign start = (int'(last) + 1) % N;
`else
    logic unused_last;
    assign unused_last = ^last;
    assign start = 0;
`endif

    // Scan candidates in rotated order; the first requester found wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && i == (start + k) % N && req[i]) begin
                    gnt[i] = 1'b1;
                    idx    = W'(i);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mps_op_cmd_arbiter.sv
// Operation ON/OFF command arbiter in front of MPS_Operation_FSM.
// Optional round-robin picking: define MPS_ARB_ROUND_ROBIN_EN.
module mps_op_cmd_arbiter
    import mps_op_pkg::*;
#(
    parameter int          N_REQ     = 3,
    parameter logic [31:0] TO_CYCLES = 32'd2000000000,
    parameter int          OWN_W     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_on_req,
    input  logic [N_REQ-1:0] i_off_req,
    input  logic [N_REQ-1:0] i_req_en,
    input  logic             i_intl,
    input  logic [3:0]       i_on_state,
    input  logic [3:0]       i_off_state,
    output logic             o_op_on_flag,
    output logic             o_op_off_flag,
    output logic [OWN_W-1:0] o_owner,
    output logic             o_busy,
    output logic             o_sys_on,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_fail,
    output logic [N_REQ-1:0] o_reject,
    output logic [2:0]       o_arb_state
);

    localparam logic [31:0] TO_LAST = TO_CYCLES - 32'd1;

    arb_state_e       state;
    logic [N_REQ-1:0] on_prev;
    logic [N_REQ-1:0] off_prev;
    logic [N_REQ-1:0] on_edge;
    logic [N_REQ-1:0] off_edge;
    logic             seen_active;
    logic [31:0]      cnt;

    logic [N_REQ-1:0] on_gnt;
    logic [N_REQ-1:0] off_gnt;
    logic [OWN_W-1:0] on_idx;
    logic [OWN_W-1:0] off_idx;
    logic             on_any;
    logic             off_any;
    logic [N_REQ-1:0] own_oh;
    logic             on_bad;

    mps_req_pick #(
        .N (N_REQ),
        .W (OWN_W)
    ) u_pick_on (
        .req  (on_edge),
        .last (o_owner),
        .gnt  (on_gnt),
        .idx  (on_idx),
        .any  (on_any)
    );

    mps_req_pick #(
        .N (N_REQ),
        .W (OWN_W)
    ) u_pick_off (
        .req  (off_edge),
        .last (o_owner),
        .gnt  (off_gnt),
        .idx  (off_idx),
        .any  (off_any)
    );

    assign own_oh      = N_REQ'(1) << o_owner;
    assign o_busy      = (state != A_IDLE);
    assign o_arb_state = state;

    // FSM dropping back to idle after having gone active counts as a failure.
    assign on_bad = (i_on_state == FAIL)
                 || (seen_active && i_on_state == ON_IDLE)
                 || (cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= A_IDLE;
            on_prev       <= '0;
            off_prev      <= '0;
            on_edge       <= '0;
            off_edge      <= '0;
            seen_active   <= 1'b0;
            cnt           <= '0;
            o_owner       <= '0;
            o_sys_on      <= 1'b0;
            o_op_on_flag  <= 1'b0;
            o_op_off_flag <= 1'b0;
            o_done        <= '0;
            o_fail        <= '0;
            o_reject      <= '0;
        end else begin
            on_prev       <= i_on_req;
            off_prev      <= i_off_req;
            on_edge       <= i_on_req & ~on_prev & i_req_en;
            off_edge      <= i_off_req & ~off_prev & i_req_en;
            o_op_on_flag  <= 1'b0;
            o_op_off_flag <= 1'b0;
            o_done        <= '0;
            o_fail        <= '0;
            o_reject      <= on_edge | off_edge;
            if (cnt != '1) begin
                cnt <= cnt + 32'd1;
            end

            unique case (state)
                A_IDLE: begin
                    if (off_any) begin
                        if (o_sys_on) begin
                            o_reject      <= on_edge | (off_edge & ~off_gnt);
                            o_owner       <= off_idx;
                            o_op_off_flag <= 1'b1;
                            state         <= A_OFF_ISSUE;
                        end
                    end else if (on_any) begin
                        if (!o_sys_on && !i_intl && i_on_state == ON_IDLE) begin
                            o_reject     <= on_edge & ~on_gnt;
                            o_owner      <= on_idx;
                            o_op_on_flag <= 1'b1;
                            state        <= A_ON_ISSUE;
                        end
                    end
                end

                A_ON_ISSUE: begin
                    if (i_intl) begin
                        o_fail   <= own_oh;
                        o_sys_on <= 1'b0;
                        state    <= A_IDLE;
                    end else begin
                        seen_active <= 1'b0;
                        cnt         <= '0;
                        state       <= A_ON_WAIT;
                    end
                end

                A_ON_WAIT: begin
                    if (i_on_state != ON_IDLE) begin
                        seen_active <= 1'b1;
                    end
                    if (i_intl) begin
                        o_fail   <= own_oh;
                        o_sys_on <= 1'b0;
                        state    <= A_IDLE;
                    end else if (i_on_state == SYSTEM_ON) begin
                        o_done   <= own_oh;
                        o_sys_on <= 1'b1;
                        state    <= A_IDLE;
                    end else if (on_bad) begin
                        o_fail <= own_oh;
                        state  <= A_IDLE;
                    end else if (off_any) begin
                        o_fail        <= own_oh;
                        o_reject      <= on_edge | (off_edge & ~off_gnt);
                        o_owner       <= off_idx;
                        o_op_off_flag <= 1'b1;
                        state         <= A_OFF_ISSUE;
                    end
                end

                A_OFF_ISSUE: begin
                    cnt   <= '0;
                    state <= A_OFF_WAIT;
                end

                A_OFF_WAIT: begin
                    if (i_off_state == OFF_SYSTEM_OFF) begin
                        o_done   <= own_oh;
                        o_sys_on <= 1'b0;
                        state    <= A_IDLE;
                    end else if (i_off_state == FAIL || cnt == TO_LAST) begin
                        o_fail   <= own_oh;
                        o_sys_on <= 1'b0;
                        state    <= A_IDLE;
                    end
                end

                default: begin
                    state <= A_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mps_op_cmd_arbiter.sv
// Bench for mps_op_cmd_arbiter: directed scenarios then random traffic,
// every cycle compared against a behavioural command-arbitration model.
module tb_mps_op_cmd_arbiter;

    localparam int N  = 3;
    localparam int TO = 1000;
`ifdef MPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] on_req = '0;
    logic [N-1:0] off_req = '0;
    logic [N-1:0] en = '1;
    logic         intl = 1'b0;
    logic [3:0]   on_state = 4'd0;
    logic [3:0]   off_state = 4'd0;

    logic         op_on;
    logic         op_off;
    logic [2:0]   owner;
    logic         busy;
    logic         sys_on;
    logic [N-1:0] done;
    logic [N-1:0] fail;
    logic [N-1:0] rej;
    logic [2:0]   arb_state;

    int n_chk = 0;
    int n_bad = 0;
    int n_onp = 0;
    int n_wait = 0;

    // Model: phase 0 idle, 1 on-issue, 2 on-wait, 3 off-issue, 4 off-wait.
    int           m_ph;
    int           m_owner;
    bit           m_sys_on;
    bit           m_seen;
    int           m_wait;
    logic [N-1:0] m_e_on, m_e_off, m_p_on, m_p_off;
    bit           e_op_on, e_op_off;
    logic [N-1:0] e_done, e_fail, e_rej;

    mps_op_cmd_arbiter #(
        .N_REQ     (N),
        .TO_CYCLES (32'(TO)),
        .OWN_W     (3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_on_req      (on_req),
        .i_off_req     (off_req),
        .i_req_en      (en),
        .i_intl        (intl),
        .i_on_state    (on_state),
        .i_off_state   (off_state),
        .o_op_on_flag  (op_on),
        .o_op_off_flag (op_off),
        .o_owner       (owner),
        .o_busy        (busy),
        .o_sys_on      (sys_on),
        .o_done        (done),
        .o_fail        (fail),
        .o_reject      (rej),
        .o_arb_state   (arb_state)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int last);
        int s;
        s = RR ? (last + 1) % N : 0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (i == (s + k) % N && v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_owner = 0; m_sys_on = 0; m_seen = 0; m_wait = 0;
        m_e_on = '0; m_e_off = '0; m_p_on = '0; m_p_off = '0;
        e_op_on = 0; e_op_off = 0;
        e_done = '0; e_fail = '0; e_rej = '0;
    endtask

    task automatic model_step();
        int oi, fi;
        logic [N-1:0] oh;
        bit bad;
        oi = pick(m_e_on, m_owner);
        fi = pick(m_e_off, m_owner);
        oh = N'(1) << m_owner;
        e_op_on = 0; e_op_off = 0;
        e_done = '0; e_fail = '0;
        e_rej = m_e_on | m_e_off;
        case (m_ph)
            0: begin
                if (fi >= 0) begin
                    if (m_sys_on) begin
                        e_rej = m_e_on | (m_e_off & ~(N'(1) << fi));
                        m_owner = fi; m_ph = 3; e_op_off = 1;
                    end
                end else if (oi >= 0) begin
                    if (!m_sys_on && !intl && on_state == 0) begin
                        e_rej = m_e_on & ~(N'(1) << oi);
                        m_owner = oi; m_ph = 1; e_op_on = 1;
                    end
                end
            end
            1: begin
                if (intl) begin
                    e_fail = oh; m_sys_on = 0; m_ph = 0;
                end else begin
                    m_seen = 0; m_wait = 0; m_ph = 2;
                end
            end
            2: begin
                bad = (on_state == 15) || (m_seen && on_state == 0)
                   || (m_wait == TO - 1);
                if (intl) begin
                    e_fail = oh; m_sys_on = 0; m_ph = 0;
                end else if (on_state == 14) begin
                    e_done = oh; m_sys_on = 1; m_ph = 0;
                end else if (bad) begin
                    e_fail = oh; m_ph = 0;
                end else if (fi >= 0) begin
                    e_fail = oh;
                    e_rej = m_e_on | (m_e_off & ~(N'(1) << fi));
                    m_owner = fi; m_ph = 3; e_op_off = 1;
                end
                if (on_state != 0) m_seen = 1;
                m_wait++;
            end
            3: begin
                m_wait = 0; m_ph = 4;
            end
            default: begin
                if (off_state == 3) begin
                    e_done = oh; m_sys_on = 0; m_ph = 0;
                end else if (off_state == 15 || m_wait == TO - 1) begin
                    e_fail = oh; m_sys_on = 0; m_ph = 0;
                end
                m_wait++;
            end
        endcase
        m_e_on  = on_req & ~m_p_on & en;
        m_e_off = off_req & ~m_p_off & en;
        m_p_on  = on_req;
        m_p_off = off_req;
    endtask

    task automatic compare();
        chk("op_on", 32'(op_on), 32'(e_op_on));
        chk("op_off", 32'(op_off), 32'(e_op_off));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("sys_on", 32'(sys_on), 32'(m_sys_on));
        chk("done", 32'(done), 32'(e_done));
        chk("fail", 32'(fail), 32'(e_fail));
        chk("reject", 32'(rej), 32'(e_rej));
        chk("state", 32'(arb_state), 32'(m_ph));
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
            if (op_on) n_onp++;
            if (arb_state == 3'd2) n_wait++;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare();
        rst = 1'b0;

        // ON by req0, FSM reports SYSTEM_ON after ~50 cycles
        n_onp = 0;
        on_req = 3'b001;
        cyc(2);
        on_state = 4'd4;
        cyc(48);
        on_state = 4'd14;
        cyc(3);
        chk("on_pulses", 32'(n_onp), 32'd1);
        on_req = '0;

        // OFF by req0 to get back to off
        off_req = 3'b001;
        cyc(6);
        off_state = 4'd3;
        cyc(2);
        off_req = '0; on_state = 4'd0; off_state = 4'd0;
        cyc(2);

        // two ON edges together, then an OFF abort from req2
        on_req = 3'b110;
        cyc(2);
        on_state = 4'd4;
        cyc(5);
        off_req = 3'b100;
        cyc(4);
        off_state = 4'd3;
        cyc(2);
        on_req = '0; off_req = '0; on_state = 4'd0; off_state = 4'd0;
        cyc(3);

        // FSM stuck active -> timeout
        on_req = 3'b001;
        cyc(2);
        on_state = 4'd4;
        n_wait = 0;
        cyc(TO + 10);
        chk("to_len", 32'(n_wait), 32'(TO));
        on_req = '0; on_state = 4'd0;
        cyc(2);

        // interlock during ON wait, then ON under interlock
        on_req = 3'b010;
        cyc(2);
        on_state = 4'd4;
        cyc(3);
        intl = 1'b1;
        cyc(2);
        on_req = '0;
        cyc(1);
        on_state = 4'd0;
        on_req = 3'b010;
        cyc(4);
        intl = 1'b0; on_req = '0;
        cyc(2);

        // OFF while off, and a disabled requester
        off_req = 3'b001;
        cyc(3);
        off_req = '0;
        en = 3'b011;
        on_req = 3'b100;
        cyc(4);
        on_req = '0; en = '1;
        cyc(2);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) on_req ^= N'(1) << $urandom_range(N - 1);
            if ($urandom_range(7) == 0) off_req ^= N'(1) << $urandom_range(N - 1);
            if ($urandom_range(255) == 0) en = N'($urandom_range(7));
            if ($urandom_range(255) == 0) en = '1;
            intl = ($urandom_range(63) == 0);
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0: on_state = 4'd0;
                    1: on_state = 4'd4;
                    2: on_state = 4'd14;
                    default: on_state = 4'd15;
                endcase
            end
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(2))
                    0: off_state = 4'd0;
                    1: off_state = 4'd3;
                    default: off_state = 4'd15;
                endcase
            end
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
